// File: rtl/rx_byte_fifo.sv
// Receive byte FIFO: stores {perr, data} pairs from the Rx datapath
// and presents the head entry first-word-fall-through.
module rx_byte_fifo #(
    parameter int DEPTH = 8,
    parameter int CW    = 4
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [7:0]    wr_data,
    input  logic          wr_perr,
    input  logic          rd_ready,
    input  logic          clr_ovf,
    output logic          rd_valid,
    output logic [7:0]    rd_data,
    output logic          rd_perr,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty,
    output logic          overflow
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [8:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] cnt;
    logic          rd_acc;
    logic          wr_acc;

    assign full     = (cnt == CW'(DEPTH));
    assign empty    = (cnt == '0);
    assign count    = cnt;
    assign rd_valid = ~empty;
    assign rd_data  = mem[rd_ptr][7:0];
    assign rd_perr  = mem[rd_ptr][8];

    // A read freeing a slot lets a write into a full FIFO land
    assign rd_acc = rd_valid & rd_ready;
    assign wr_acc = wr_en & (~full | rd_acc);

    always_ff @(posedge clock) begin
        if (wr_acc && !reset)
            mem[wr_ptr] <= {wr_perr, wr_data};
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (wr_acc)
                wr_ptr <= wr_ptr + 1'b1;
            if (rd_acc)
                rd_ptr <= rd_ptr + 1'b1;
            if (wr_acc && !rd_acc)
                cnt <= cnt + 1'b1;
            else if (rd_acc && !wr_acc)
                cnt <= cnt - 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset)
            overflow <= 1'b0;
        else if (wr_en && !wr_acc)
            overflow <= 1'b1;
        else if (clr_ovf)
            overflow <= 1'b0;
    end

endmodule

// File: tb/tb_rx_byte_fifo.sv
// Scoreboard bench for rx_byte_fifo: directed scenarios followed by
// randomized traffic, checked against a queue-based reference model.
module tb_rx_byte_fifo;

    localparam int DEPTH = 8;
    localparam int CW    = 4;

    logic          clock;
    logic          reset;
    logic          wr_en;
    logic [7:0]    wr_data;
    logic          wr_perr;
    logic          rd_ready;
    logic          clr_ovf;
    logic          rd_valid;
    logic [7:0]    rd_data;
    logic          rd_perr;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    logic          overflow;

    rx_byte_fifo #(.DEPTH(DEPTH), .CW(CW)) dut (
        .clock(clock),
        .reset(reset),
        .wr_en(wr_en),
        .wr_data(wr_data),
        .wr_perr(wr_perr),
        .rd_ready(rd_ready),
        .clr_ovf(clr_ovf),
        .rd_valid(rd_valid),
        .rd_data(rd_data),
        .rd_perr(rd_perr),
        .count(count),
        .full(full),
        .empty(empty),
        .overflow(overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int         n_vec = 0;
    int         n_err = 0;
    logic [8:0] sb_q[$];
    int         exp_count = 0;
    logic       exp_ovf = 1'b0;
    logic       started = 1'b0;

    task automatic check(input string name, input int act, input int req);
        n_vec++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t",
                     name, act, req, $time);
        end
    endtask

    // Reference model: occupancy and sticky flag, updated on each edge
    always @(posedge clock) begin
        bit ra;
        bit wa;
        if (reset) begin
            sb_q.delete();
            exp_count = 0;
            exp_ovf   = 1'b0;
            started   = 1'b1;
        end else if (started) begin
            ra = (exp_count > 0) && rd_ready;
            wa = wr_en && ((exp_count < DEPTH) || ra);
            if (wa)
                sb_q.push_back({wr_perr, wr_data});
            exp_count = exp_count + int'(wa) - int'(ra);
            if (wr_en && !wa)
                exp_ovf = 1'b1;
            else if (clr_ovf)
                exp_ovf = 1'b0;
        end
    end

    // Monitor: status every cycle, data whenever a read is accepted
    always @(negedge clock) begin
        logic [8:0] e;
        if (started) begin
            check("count", int'(count), exp_count);
            check("rd_valid", int'(rd_valid), int'(exp_count != 0));
            check("full", int'(full), int'(exp_count == DEPTH));
            check("empty", int'(empty), int'(exp_count == 0));
            check("overflow", int'(overflow), int'(exp_ovf));
            if (rd_valid === 1'b1 && rd_ready && !reset) begin
                if (sb_q.size() == 0) begin
                    check("sb_underflow", 1, 0);
                end else begin
                    e = sb_q.pop_front();
                    check("rd_data", int'(rd_data), int'(e[7:0]));
                    check("rd_perr", int'(rd_perr), int'(e[8]));
                end
            end
        end
    end

    task automatic step(input logic w, input logic [7:0] d,
                        input logic p, input logic r,
                        input logic c, input logic rs);
        @(posedge clock);
        #1;
        wr_en    = w;
        wr_data  = d;
        wr_perr  = p;
        rd_ready = r;
        clr_ovf  = c;
        reset    = rs;
    endtask

    task automatic idle();
        step(0, 8'h00, 0, 0, 0, 0);
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 1; i++)
            step(0, 8'h00, 0, 1, 0, 0);
    endtask

    initial begin
        wr_en    = 1'b0;
        wr_data  = 8'h00;
        wr_perr  = 1'b0;
        rd_ready = 1'b0;
        clr_ovf  = 1'b0;
        reset    = 1'b1;
        step(0, 8'h00, 0, 0, 0, 1);
        idle();

        // single byte
        step(1, 8'hA5, 0, 0, 0, 0);
        idle();
        step(0, 8'h00, 0, 1, 0, 0);
        idle();

        // fill and overflow
        for (int i = 0; i < 9; i++)
            step(1, 8'(i), 0, 0, 0, 0);
        idle();
        drain();
        step(0, 8'h00, 0, 0, 1, 0);
        idle();

        // simultaneous write and read while full
        for (int i = 0; i < DEPTH; i++)
            step(1, 8'(8'h10 + i), 0, 0, 0, 0);
        step(1, 8'h3C, 0, 1, 0, 0);
        idle();
        drain();

        // wrap with perr on every third byte
        for (int i = 0; i < 20; i++) begin
            step(1, 8'(8'h40 + i), (i % 3) == 2, 0, 0, 0);
            step(0, 8'h00, 0, 1, 0, 0);
        end
        idle();

        // overflow clear racing a dropped write
        for (int i = 0; i < DEPTH + 1; i++)
            step(1, 8'(8'h80 + i), 0, 0, 0, 0);
        step(1, 8'hEE, 1, 0, 1, 0);
        step(0, 8'h00, 0, 0, 1, 0);
        idle();
        drain();

        // reset mid-stream with a pending write
        for (int i = 0; i < 5; i++)
            step(1, 8'(8'hC0 + i), 1, 0, 0, 0);
        step(1, 8'h77, 0, 0, 0, 1);
        idle();
        idle();

        // randomized traffic with shifting read bias
        for (int i = 0; i < 3000; i++) begin
            int rb;
            rb = (i / 250) % 3;
            step($urandom_range(0, 99) < 55,
                 8'($urandom),
                 1'($urandom),
                 $urandom_range(0, 99) < (rb == 0 ? 20 :
                                          rb == 1 ? 50 : 85),
                 $urandom_range(0, 99) < 5,
                 $urandom_range(0, 299) == 0);
        end
        drain();
        idle();
        @(posedge clock);
        #2;
        check("sb_residue", sb_q.size(), exp_count);
        @(negedge clock);
        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rx_byte_fifo.md
RX_BYTE_FIFO -- requirements
Module: rx_byte_fifo

Interface
REQ-001 Parameter DEPTH, 8, number of byte entries; power of two, range 2..64.
REQ-002 Parameter CW, 4, count width; equals log2(DEPTH)+1.
REQ-003 clock  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 wr_en  input  1  one-cycle strobe from Rx datapath (data_load); wr_data/wr_perr valid this cycle.
REQ-006 wr_data  input  8  received byte from SIPO.
REQ-007 wr_perr  input  1  parity-error flag for this byte (1 = mismatch).
REQ-008 rd_ready  input  1  consumer accepts head entry this cycle.
REQ-009 clr_ovf  input  1  clears sticky overflow flag.
REQ-010 rd_valid  output  1  head entry present on rd_data/rd_perr.
REQ-011 rd_data  output  8  head byte, first-word-fall-through.
REQ-012 rd_perr  output  1  parity-error flag of head byte.
REQ-013 count  output  CW  number of stored entries, 0..DEPTH.
REQ-014 full  output  1  count == DEPTH.
REQ-015 empty  output  1  count == 0.
REQ-016 overflow  output  1  sticky; a write was dropped.

Function
REQ-017 Storage SHALL be a DEPTH x 9-bit array {perr, data} with write pointer, read pointer and count registers.
REQ-018 Write accepted SHALL mean wr_en=1 and (full=0 or read accepted in same cycle); the entry is stored at wr_ptr and wr_ptr advances by 1.
REQ-019 Read accepted SHALL mean rd_valid=1 and rd_ready=1; rd_ptr advances by 1.
REQ-020 rd_valid SHALL equal ~empty; rd_data/rd_perr SHALL reflect the entry at rd_ptr combinationally from the registered array.
REQ-021 Latency: a write into an empty FIFO at edge N SHALL make rd_valid=1 with that byte in the cycle following edge N.
REQ-022 Pointers SHALL wrap from DEPTH-1 to 0, modulo DEPTH, without extra state.
REQ-023 count SHALL increase by 1 on write-only, decrease by 1 on read-only, and hold on simultaneous write+read or on neither.
REQ-024 Simultaneous write and read when full SHALL accept both; count stays DEPTH; no overflow.
REQ-025 Simultaneous write and read when empty SHALL accept only the write (rd_valid=0 that cycle); count becomes 1.
REQ-026 A write while full without an accepted read SHALL be dropped, leave array/pointers/count unchanged, and set overflow=1.
REQ-027 rd_ready while empty SHALL be ignored; no pointer or count change.
REQ-028 overflow SHALL remain 1 until clr_ovf=1; if clr_ovf and a dropped write coincide, overflow SHALL be 1 (set wins).
REQ-029 Entry ordering SHALL be strict FIFO; wr_perr SHALL travel with its byte unmodified.
REQ-030 full and empty SHALL be derived from count and never both 1.

Reset
REQ-031 With reset=1 at a rising edge, wr_ptr, rd_ptr, count SHALL be 0 and overflow SHALL be 0; the next cycle shows empty=1, full=0, rd_valid=0.
REQ-032 Reset SHALL take priority over wr_en, rd_ready and clr_ovf in the same cycle; a pending write is discarded.
REQ-033 Array contents SHALL not be reset; rd_data/rd_perr are don't-care while rd_valid=0.
REQ-034 Reset asserted mid-operation (count>0) SHALL discard all entries at that edge.

Verification
REQ-035 Single byte: write 0xA5, perr=0 into empty FIFO, rd_ready=0 -> next cycle rd_valid=1, rd_data=0xA5, count=1; pulse rd_ready -> empty=1, count=0.
REQ-036 Fill/overflow: write 0x00..0x08 (9 bytes) with rd_ready=0 -> full=1 after the 8th, 9th dropped, overflow=1, reads return 0x00..0x07 in order.
REQ-037 Full simultaneous: full FIFO, wr_en=1 with 0x3C plus rd_ready=1 -> count stays 8, overflow=0, 0x3C read last after draining the 7 earlier entries.
REQ-038 Wrap and perr: 20 interleaved writes/reads with perr=1 on every 3rd byte -> data order and perr flags preserved across pointer wrap.
REQ-039 Overflow clear: overflow=1, clr_ovf=1 with a dropped write in the same cycle -> overflow stays 1; clr_ovf alone next cycle -> overflow=0.
REQ-040 Reset mid-stream: count=5, reset=1 with wr_en=1 -> next cycle count=0, empty=1, overflow=0, rd_valid=0.
